// File: rtl/sprite_motion_pkg.sv
// Shared definitions for the player sprite motion controller: state encoding
// and a coordinate clamp helper.
package sprite_motion_pkg;

    localparam logic [1:0] GROUND = 2'd0;
    localparam logic [1:0] RISE   = 2'd1;
    localparam logic [1:0] FALL   = 2'd2;
    localparam logic [1:0] DUCK   = 2'd3;

    typedef enum logic [1:0] {
        StGround = GROUND,
        StRise   = RISE,
        StFall   = FALL,
        StDuck   = DUCK
    } motion_state_e;

    function automatic int clamp_int(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop button synchronizer; EDGE=1 turns the output into a one-cycle
// pulse on each synchronized rising edge.
module btn_sync #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic sig_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    if (EDGE) begin : g_edge
        logic prev_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= sync_q;
            end
        end

        assign sig_o = sync_q & ~prev_q;
    end else begin : g_level
        assign sig_o = sync_q;
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame position and jump/duck physics for the player sprite. All motion
// state advances only on the frame pulse so the renderer never sees a tear.
module sprite_motion_ctrl
    import sprite_motion_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int START_X   = 143,
    parameter int GROUND_Y  = 400,
    parameter int H_MIN     = 144,
    parameter int H_MAX     = 775,
    parameter int SPR_WIDTH = 8,
    parameter int H_STEP    = 2,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    btn_jump,
    input  logic                    btn_duck,
    input  logic                    btn_left,
    input  logic                    btn_right,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic [1:0]              mstate,
    output logic                    ducking
);

    localparam int VEL_MAX = (JUMP_V0 > MAX_FALL) ? JUMP_V0 : MAX_FALL;
    localparam int VW      = $clog2(VEL_MAX) + 1;
    localparam logic signed [CORDW:0] H_STEP_W = (CORDW+1)'(H_STEP);

    logic jump_edge;
    logic duck_s;
    logic left_s;
    logic right_s;

    btn_sync #(.EDGE(1'b1)) u_sync_jump (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_jump),
        .sig_o (jump_edge)
    );

    btn_sync #(.EDGE(1'b0)) u_sync_duck (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_duck),
        .sig_o (duck_s)
    );

    btn_sync #(.EDGE(1'b0)) u_sync_left (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_left),
        .sig_o (left_s)
    );

    btn_sync #(.EDGE(1'b0)) u_sync_right (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_right),
        .sig_o (right_s)
    );

    motion_state_e           state_q, state_d;
    logic [CORDW-1:0]        sprx_q, sprx_d;
    logic signed [CORDW-1:0] spry_q, spry_d;
    logic [VW-1:0]           vel_q, vel_d;
    logic                    ducking_q;
    logic                    jump_pend_q;
    logic                    jump_now;

    int y_cur;
    int v_cur;
    int y_new;
    int v_new;

    // Vertical physics and state transitions
    always_comb begin
        jump_now = jump_pend_q | jump_edge;
        state_d  = state_q;
        spry_d   = spry_q;
        vel_d    = vel_q;
        y_cur    = int'(spry_q);
        v_cur    = int'(vel_q);
        y_new    = 0;
        v_new    = 0;
        unique case (state_q)
            StGround: begin
                if (jump_now) begin
                    state_d = StRise;
                    vel_d   = VW'(JUMP_V0);
                end else if (duck_s) begin
                    state_d = StDuck;
                end
            end
            StDuck: begin
                if (jump_now) begin
                    state_d = StRise;
                    vel_d   = VW'(JUMP_V0);
                end else if (!duck_s) begin
                    state_d = StGround;
                end
            end
            StRise: begin
                y_new = y_cur - v_cur;
                if (y_new < 0) begin
                    spry_d  = '0;
                    vel_d   = '0;
                    state_d = StFall;
                end else begin
                    v_new  = (v_cur > GRAVITY) ? v_cur - GRAVITY : 0;
                    spry_d = CORDW'(y_new);
                    vel_d  = VW'(v_new);
                    if (v_new == 0) begin
                        state_d = StFall;
                    end
                end
            end
            StFall: begin
                v_new = (v_cur + GRAVITY > MAX_FALL) ? MAX_FALL : v_cur + GRAVITY;
                y_new = y_cur + v_new;
                if (y_new >= GROUND_Y) begin
                    spry_d  = CORDW'(GROUND_Y);
                    vel_d   = '0;
                    state_d = StGround;
                end else begin
                    spry_d = CORDW'(y_new);
                    vel_d  = VW'(v_new);
                end
            end
            default: ;
        endcase
    end

    // x spans the full unsigned range of CORDW bits, so it is zero-extended
    // into one extra bit before stepping and clamping.
    logic signed [CORDW:0] x_wide;
    logic signed [CORDW:0] x_sum;

    always_comb begin
        x_wide = $signed({1'b0, sprx_q});
        x_sum  = x_wide;
        if (left_s && !right_s) begin
            x_sum = x_wide - H_STEP_W;
        end else if (right_s && !left_s) begin
            x_sum = x_wide + H_STEP_W;
        end
        sprx_d = CORDW'(clamp_int(int'(x_sum), H_MIN, H_MAX - SPR_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGround;
            sprx_q      <= CORDW'(START_X);
            spry_q      <= CORDW'(GROUND_Y);
            vel_q       <= '0;
            ducking_q   <= 1'b0;
            jump_pend_q <= 1'b0;
        end else if (frame) begin
            state_q     <= state_d;
            sprx_q      <= sprx_d;
            spry_q      <= spry_d;
            vel_q       <= vel_d;
            ducking_q   <= (state_d == StDuck);
            jump_pend_q <= 1'b0;
        end else if (jump_edge) begin
            jump_pend_q <= 1'b1;
        end
    end

    assign sprx    = sprx_q;
    assign spry    = spry_q;
    assign mstate  = state_q;
    assign ducking = ducking_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized and directed bench for sprite_motion_ctrl against a frame-level
// behavioural model of the duck's motion.
module tb_sprite_motion_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic frame;
    logic btn_jump;
    logic btn_duck;
    logic btn_left;
    logic btn_right;
    logic signed [9:0] sprx;
    logic signed [9:0] spry;
    logic [1:0] mstate;
    logic ducking;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .btn_jump  (btn_jump),
        .btn_duck  (btn_duck),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .sprx      (sprx),
        .spry      (spry),
        .mstate    (mstate),
        .ducking   (ducking)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model state
    int m_x;
    int m_y;
    int m_v;
    int m_st;
    bit m_jump_seen;
    bit prev_jump;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_sprx"}, int'({22'd0, sprx}), m_x);
        check_val({tag, "_spry"}, int'(spry), m_y);
        check_val({tag, "_mstate"}, int'(mstate), m_st);
        check_val({tag, "_ducking"}, int'(ducking), (m_st == 3) ? 1 : 0);
    endtask

    task automatic drive_jump(input bit v);
        if (v && !prev_jump) m_jump_seen = 1'b1;
        prev_jump = v;
        btn_jump  = v;
    endtask

    task automatic model_reset();
        m_x = 143;
        m_y = 400;
        m_v = 0;
        m_st = 0;
        m_jump_seen = 1'b0;
        prev_jump = 1'b0;
    endtask

    task automatic model_frame(input bit duck, input bit left, input bit right);
        bit jmp;
        int vn;
        jmp = m_jump_seen;
        m_jump_seen = 1'b0;
        if (m_st == 0 || m_st == 3) begin
            if (jmp) begin
                m_st = 1;
                m_v = 12;
            end else begin
                m_st = duck ? 3 : 0;
            end
        end else if (m_st == 1) begin
            if (m_y - m_v < 0) begin
                m_y = 0;
                m_v = 0;
                m_st = 2;
            end else begin
                m_y = m_y - m_v;
                m_v = (m_v > 1) ? m_v - 1 : 0;
                if (m_v == 0) m_st = 2;
            end
        end else begin
            vn = (m_v + 1 > 12) ? 12 : m_v + 1;
            if (m_y + vn >= 400) begin
                m_y = 400;
                m_v = 0;
                m_st = 0;
            end else begin
                m_y = m_y + vn;
                m_v = vn;
            end
        end
        if (left && !right) m_x = m_x - 2;
        else if (right && !left) m_x = m_x + 2;
        if (m_x < 144) m_x = 144;
        if (m_x > 767) m_x = 767;
    endtask

    // One frame period: optional noise, settled buttons, then a frame pulse.
    task automatic step_frame(input bit jf, input bit df, input bit lf, input bit rf,
                              input bit noisy);
        if (noisy) begin
            repeat (3) begin
                @(negedge clk);
                check_outputs("hold");
                drive_jump(1'($urandom_range(0, 1)));
                btn_duck  = 1'($urandom_range(0, 1));
                btn_left  = 1'($urandom_range(0, 1));
                btn_right = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        check_outputs("hold");
        drive_jump(jf);
        btn_duck  = df;
        btn_left  = lf;
        btn_right = rf;
        repeat (4) begin
            @(negedge clk);
            check_outputs("hold");
        end
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        model_frame(df, lf, rf);
        check_outputs("frame");
    endtask

    task automatic pulse_jump();
        @(negedge clk);
        drive_jump(1'b1);
        repeat (2) @(negedge clk);
        drive_jump(1'b0);
    endtask

    task automatic do_reset(input int cycles, input bit toggle);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) begin
            if (toggle) begin
                btn_jump  = 1'($urandom_range(0, 1));
                btn_duck  = 1'($urandom_range(0, 1));
                btn_left  = 1'($urandom_range(0, 1));
                btn_right = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        rst = 1'b0;
        btn_jump  = 1'b0;
        btn_duck  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        model_reset();
    endtask

    initial begin
        int rises;
        bit was_rise;
        rst = 1'b1;
        frame = 1'b0;
        btn_jump = 1'b0;
        btn_duck = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        model_reset();

        // Reset with buttons toggling
        do_reset(3, 1'b1);
        @(negedge clk);
        check_val("rst_sprx", int'({22'd0, sprx}), 143);
        check_val("rst_spry", int'(spry), 400);
        check_val("rst_mstate", int'(mstate), 0);
        check_val("rst_ducking", int'(ducking), 0);

        // Full jump profile
        pulse_jump();
        for (int p = 1; p <= 30; p++) begin
            step_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (p == 1) check_val("jump_p1_mstate", int'(mstate), 1);
            if (p == 2) check_val("jump_p2_spry", int'(spry), 388);
            if (p == 13) begin
                check_val("jump_apex_spry", int'(spry), 322);
                check_val("jump_apex_mstate", int'(mstate), 2);
            end
            if (p == 25 || p == 30) begin
                check_val("jump_land_spry", int'(spry), 400);
                check_val("jump_land_mstate", int'(mstate), 0);
            end
        end

        // Held jump: exactly one takeoff
        rises = 0;
        was_rise = 1'b0;
        for (int p = 0; p < 40; p++) begin
            step_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (mstate == 2'd1 && !was_rise) rises++;
            was_rise = (mstate == 2'd1);
        end
        check_val("held_jump_count", rises, 1);
        check_val("held_jump_mstate", int'(mstate), 0);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Duck, then jump out of duck, with duck held while airborne
        step_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("duck_mstate", int'(mstate), 3);
        check_val("duck_flag", int'(ducking), 1);
        step_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("duck_jump_mstate", int'(mstate), 1);
        for (int p = 0; p < 26; p++) step_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("unduck_mstate", int'(mstate), 0);
        // Duck and jump in the same frame from ground
        step_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("duck_and_jump_mstate", int'(mstate), 1);
        for (int p = 0; p < 26; p++) step_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Horizontal clamps
        for (int p = 0; p < 400; p++) step_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("clamp_right", int'({22'd0, sprx}), 767);
        for (int p = 0; p < 400; p++) step_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("clamp_left", int'({22'd0, sprx}), 144);
        for (int p = 0; p < 10; p++) step_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 5; p++) step_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("both_held", int'({22'd0, sprx}), 164);

        // Reset in the middle of the rise
        pulse_jump();
        for (int p = 0; p < 6; p++) step_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("midjump_spry", int'(spry), 350);
        check_val("midjump_mstate", int'(mstate), 1);
        do_reset(1, 1'b0);
        check_val("midjump_rst_spry", int'(spry), 400);
        check_val("midjump_rst_mstate", int'(mstate), 0);
        check_val("midjump_rst_sprx", int'({22'd0, sprx}), 143);

        // Random traffic with noise between pulses
        for (int p = 0; p < 250; p++) begin
            step_frame(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
